n64_pi_bus_master: RTL and testbench

//  Synthesizable N64 PI (cartridge AD16) bus initiator: the console side of the bus the cart responder (Main) serves.

---
 rtl/n64_pi_bus_master.sv | 178 +++++++++++++++++
 tb/tb_n64_pi_bus_master.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_pi_bus_master.sv
// rtl/n64_pi_bus_master.sv - N64 PI AD16 bus initiator: host command to ALE/strobe/AD sequence
// Every bus-facing output comes straight from a flop so the cart never sees combinational glitches.
module n64_pi_bus_master #(
  parameter int T_ALE  = 3,
  parameter int T_TURN = 2,
  parameter int T_LOW  = 4,
  parameter int T_HIGH = 2,
  parameter int T_END  = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [8:0]  cmd_len,
  input  logic [15:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done,
  output logic [15:0] AD_o,
  output logic        AD_oe,
  input  logic [15:0] AD_i,
  output logic        ALE_H,
  output logic        ALE_L,
  output logic        READ_N,
  output logic        WRITE_N
);

  localparam logic [7:0] ALE_M1  = 8'(T_ALE - 1);
  localparam logic [7:0] TURN_M1 = 8'(T_TURN - 1);
  localparam logic [7:0] LOW_M1  = 8'(T_LOW - 1);
  localparam logic [7:0] HIGH_M1 = 8'(T_HIGH - 1);
  localparam logic [7:0] END_M1  = 8'(T_END - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_TURN, S_STB_LO, S_STB_HI, S_END
  } state_e;

  state_e      state_q;
  logic [7:0]  timer_q;
  logic [8:0]  count_q;
  logic        write_q;
  logic [15:0] addr_lo_q;
  logic        cmd_ready_q;
  logic        wr_ready_q;
  logic [15:0] rd_data_q;
  logic        rd_valid_q;
  logic        done_q;
  logic [15:0] ad_o_q;
  logic        ad_oe_q;
  logic        ale_h_q;
  logic        ale_l_q;
  logic        read_n_q;
  logic        write_n_q;
  logic        launch;

  // A write strobe may only start once a data word is on offer; reads never wait.
  assign launch = !write_q || wr_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      timer_q     <= 8'd0;
      count_q     <= 9'd0;
      write_q     <= 1'b0;
      addr_lo_q   <= 16'h0000;
      cmd_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      rd_data_q   <= 16'h0000;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      ad_o_q      <= 16'h0000;
      ad_oe_q     <= 1'b0;
      ale_h_q     <= 1'b1;
      ale_l_q     <= 1'b1;
      read_n_q    <= 1'b1;
      write_n_q   <= 1'b1;
    end else begin
      rd_valid_q <= 1'b0;
      wr_ready_q <= 1'b0;
      done_q     <= 1'b0;
      if (timer_q != 8'd0) timer_q <= timer_q - 8'd1;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            state_q     <= S_ADDR_H;
            timer_q     <= ALE_M1;
            count_q     <= (cmd_len == 9'd0) ? 9'd256 : cmd_len;
            write_q     <= cmd_write;
            addr_lo_q   <= cmd_addr[15:0];
            cmd_ready_q <= 1'b0;
            ad_o_q      <= cmd_addr[31:16];
            ad_oe_q     <= 1'b1;
            ale_h_q     <= 1'b0;
          end
        end
        S_ADDR_H: begin
          if (timer_q == 8'd0) begin
            state_q <= S_ADDR_L;
            timer_q <= ALE_M1;
            ad_o_q  <= addr_lo_q;
            ale_l_q <= 1'b0;
          end
        end
        S_ADDR_L: begin
          if (timer_q == 8'd0) begin
            state_q <= S_TURN;
            timer_q <= TURN_M1;
            ad_oe_q <= 1'b0;
          end
        end
        S_TURN, S_STB_HI: begin
          if (timer_q == 8'd0) begin
            if (state_q == S_STB_HI && count_q == 9'd1) begin
              state_q <= S_END;
              timer_q <= END_M1;
              count_q <= count_q - 9'd1;
              ale_h_q <= 1'b1;
              ale_l_q <= 1'b1;
              ad_oe_q <= 1'b0;
            end else if (launch) begin
              if (state_q == S_STB_HI) count_q <= count_q - 9'd1;
              state_q <= S_STB_LO;
              timer_q <= LOW_M1;
              if (write_q) begin
                write_n_q  <= 1'b0;
                wr_ready_q <= 1'b1;
                ad_o_q     <= wr_data;
                ad_oe_q    <= 1'b1;
              end else begin
                read_n_q <= 1'b0;
              end
            end
          end
        end
        S_STB_LO: begin
          if (timer_q == 8'd0) begin
            state_q <= S_STB_HI;
            timer_q <= HIGH_M1;
            if (write_q) begin
              write_n_q <= 1'b1;
            end else begin
              read_n_q   <= 1'b1;
              rd_data_q  <= AD_i;
              rd_valid_q <= 1'b1;
            end
          end
        end
        S_END: begin
          if (timer_q == 8'd0) begin
            state_q     <= S_IDLE;
            done_q      <= 1'b1;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = ~cmd_ready_q;
  assign wr_ready  = wr_ready_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign AD_o      = ad_o_q;
  assign AD_oe     = ad_oe_q;
  assign ALE_H     = ale_h_q;
  assign ALE_L     = ale_l_q;
  assign READ_N    = read_n_q;
  assign WRITE_N   = write_n_q;

endmodule

// File: tb/tb_n64_pi_bus_master.sv
// tb/tb_n64_pi_bus_master.sv - bench for n64_pi_bus_master with cart responder and write-data feeder
module tb_n64_pi_bus_master;
  localparam int T_ALE = 3, T_TURN = 2, T_LOW = 4, T_HIGH = 2, T_END = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [8:0]  cmd_len = '0;
  logic [15:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic [15:0] AD_i = '0;
  logic        cmd_ready, wr_ready, rd_valid, busy, done, AD_oe;
  logic        ALE_H, ALE_L, READ_N, WRITE_N;
  logic [15:0] rd_data, AD_o;

  n64_pi_bus_master #(.T_ALE(T_ALE), .T_TURN(T_TURN), .T_LOW(T_LOW), .T_HIGH(T_HIGH), .T_END(T_END)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done), .AD_o(AD_o), .AD_oe(AD_oe),
    .AD_i(AD_i), .ALE_H(ALE_H), .ALE_L(ALE_L), .READ_N(READ_N), .WRITE_N(WRITE_N)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int burst_cycles(input int n);
    return 1 + 2 * T_ALE + T_TURN + n * (T_LOW + T_HIGH) + T_END;
  endfunction

  // cart responder: presents the next word of rsp[] as soon as READ_N falls
  logic [15:0] rsp[0:255];
  int rsp_idx = 0;
  always @(negedge READ_N) begin
    AD_i = (rsp_idx < 256) ? rsp[rsp_idx] : 16'hDEAD;
    rsp_idx++;
  end

  // write-data source with an optional stall after word stall_at is taken
  logic [15:0] wq[0:255];
  int wn = 0, widx = 0, stall_at = -1, stall_len = 0, stall_left = 0;
  logic hs = 1'b0;
  always @(negedge clk) hs = wr_valid && wr_ready;
  always @(posedge clk) begin
    #1;
    if (hs) begin
      widx++;
      if (widx == stall_at) stall_left = stall_len;
    end else if (stall_left > 0) begin
      stall_left--;
    end
    wr_valid = (widx < wn) && (stall_left == 0);
    wr_data  = (widx < wn) ? wq[widx] : 16'h0000;
  end

  // bus monitor
  int n_rfall, n_wfall, n_rv, n_wr, n_done, err_inv, rlow, wlow, acc_cyc, wv_rise_cyc;
  logic [15:0] q_ah[$], q_al[$], q_rd[$], q_wb[$];
  int q_dur[$], ah_fall_cyc[$], ah_rise_cyc[$], wfall_cyc[$];
  logic p_ah = 1'b1, p_al = 1'b1, p_rn = 1'b1, p_wn = 1'b1, p_wv = 1'b0;
  logic [15:0] w_hold;

  always @(negedge resetn) begin
    p_ah = 1'b1; p_al = 1'b1; p_rn = 1'b1; p_wn = 1'b1;
    rlow = 0; wlow = 0;
  end

  always @(negedge clk) begin
    if (resetn) begin
      if (done) begin n_done++; q_dur.push_back(cyc - acc_cyc); end
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (!ALE_H && p_ah) begin q_ah.push_back(AD_o); ah_fall_cyc.push_back(cyc); end
      if (ALE_H && !p_ah) ah_rise_cyc.push_back(cyc);
      if (!ALE_L && p_al) q_al.push_back(AD_o);
      if (!READ_N) begin
        if (p_rn) n_rfall++;
        rlow++;
        if (AD_oe) err_inv++;
      end else if (!p_rn) begin
        if (rlow != T_LOW) err_inv++;
        rlow = 0;
      end
      if (!WRITE_N) begin
        if (p_wn) begin
          n_wfall++; wfall_cyc.push_back(cyc); q_wb.push_back(AD_o); w_hold = AD_o;
        end else if (AD_o !== w_hold) begin
          err_inv++;
        end
        if (!AD_oe) err_inv++;
        wlow++;
      end else if (!p_wn) begin
        if (wlow != T_LOW) err_inv++;
        wlow = 0;
      end
      if ((!READ_N || !WRITE_N) && (ALE_H || ALE_L)) err_inv++;
      if (rd_valid) begin n_rv++; q_rd.push_back(rd_data); end
      if (wr_ready) n_wr++;
      if (wr_valid && !p_wv) wv_rise_cyc = cyc;
      p_ah = ALE_H; p_al = ALE_L; p_rn = READ_N; p_wn = WRITE_N; p_wv = wr_valid;
    end
  end

  task automatic clear_mon();
    n_rfall = 0; n_wfall = 0; n_rv = 0; n_wr = 0; n_done = 0; err_inv = 0;
    acc_cyc = 0; wv_rise_cyc = 0;
    q_ah.delete(); q_al.delete(); q_rd.delete(); q_wb.delete();
    q_dur.delete(); ah_fall_cyc.delete(); ah_rise_cyc.delete(); wfall_cyc.delete();
  endtask

  task automatic prep(input logic w, input int n);
    clear_mon();
    rsp_idx = 0;
    widx = 0; stall_at = -1; stall_left = 0;
    wn = w ? n : 0;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [8:0] l);
    @(posedge clk); #1;
    cmd_write = w; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int target);
    for (int k = 0; k < 4000 && n_done < target; k++) @(negedge clk);
    chk({nm, ".done_within_budget"}, (n_done >= target), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_burst(input string nm, input logic w, input logic [15:0] ah,
                             input logic [15:0] al, input int n, input int dur);
    chk({nm, ".ale_h_falls"}, q_ah.size(), 1);
    chk({nm, ".ale_h_addr"}, (q_ah.size() > 0) ? longint'(q_ah[0]) : -1, ah);
    chk({nm, ".ale_l_addr"}, (q_al.size() > 0) ? longint'(q_al[0]) : -1, al);
    chk({nm, ".strobes"}, w ? n_wfall : n_rfall, n);
    chk({nm, ".other_strobes"}, w ? n_rfall : n_wfall, 0);
    chk({nm, ".handshakes"}, w ? n_wr : n_rv, n);
    for (int i = 0; i < n; i++) begin
      if (w) chk({nm, $sformatf(".wr_bus[%0d]", i)}, (i < q_wb.size()) ? longint'(q_wb[i]) : -1, wq[i]);
      else   chk({nm, $sformatf(".rd_data[%0d]", i)}, (i < q_rd.size()) ? longint'(q_rd[i]) : -1, rsp[i]);
    end
    chk({nm, ".done_pulses"}, n_done, 1);
    if (dur >= 0) chk({nm, ".cycles"}, (q_dur.size() > 0) ? q_dur[0] : -1, dur);
    chk({nm, ".bus_rules"}, err_inv, 0);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [8:0]  len;
    logic [15:0] ah;
    logic [15:0] al;
    int          n;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 32'h0000_0000, 9'd4,   16'h0000, 16'h0000, 4};
    tbl[1] = '{1'b0, 32'h0001_B420, 9'd1,   16'h0001, 16'hB420, 1};
    tbl[2] = '{1'b1, 32'h1000_0000, 9'd3,   16'h1000, 16'h0000, 3};
    tbl[3] = '{1'b0, 32'hDEAD_BEEF, 9'd0,   16'hDEAD, 16'hBEEF, 256};
    tbl[4] = '{1'b1, 32'h8000_0002, 9'd2,   16'h8000, 16'h0002, 2};
    tbl[5] = '{1'b1, 32'hFFFF_FFFF, 9'd1,   16'hFFFF, 16'hFFFF, 1};
    clear_mon();

    // reset state
    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.ale_h", ALE_H, 1);   chk("rst.ale_l", ALE_L, 1);
    chk("rst.read_n", READ_N, 1); chk("rst.write_n", WRITE_N, 1);
    chk("rst.ad_oe", AD_oe, 0);   chk("rst.ad_o", AD_o, 0);
    chk("rst.cmd_ready", cmd_ready, 1); chk("rst.busy", busy, 0);
    chk("rst.rd_valid", rd_valid, 0);   chk("rst.wr_ready", wr_ready, 0);
    chk("rst.done", done, 0);           chk("rst.rd_data", rd_data, 0);
    @(posedge clk); #3 resetn = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle.ale_h_falls", q_ah.size(), 0);
    chk("idle.strobes", n_rfall + n_wfall, 0);
    chk("idle.cmd_ready", cmd_ready, 1);

    // table-driven bursts
    for (int v = 0; v < 6; v++) begin
      prep(tbl[v].w, tbl[v].n);
      for (int i = 0; i < 256; i++) begin
        rsp[i] = 16'((i + 1) * 16'h1111);
        wq[i]  = 16'(16'hA5A5 ^ (i * 16'h0307));
      end
      issue(tbl[v].w, tbl[v].addr, tbl[v].len);
      wait_done($sformatf("tbl%0d", v), 1);
      check_burst($sformatf("tbl%0d", v), tbl[v].w, tbl[v].ah, tbl[v].al, tbl[v].n, burst_cycles(tbl[v].n));
    end

    // write with wr_valid withdrawn for 10 cycles ahead of the second word
    prep(1'b1, 3);
    wq[0] = 16'hAAAA; wq[1] = 16'h5555; wq[2] = 16'h1234;
    stall_at = 1; stall_len = 10;
    issue(1'b1, 32'h1000_0000, 9'd3);
    wait_done("stall", 1);
    check_burst("stall", 1'b1, 16'h1000, 16'h0000, 3, -1);
    chk("stall.fall_after_valid", (wfall_cyc.size() > 1) ? wfall_cyc[1] - wv_rise_cyc : -1, 1);
    chk("stall.gap_stretched", (wfall_cyc.size() > 1) && (wfall_cyc[1] - wfall_cyc[0] > T_LOW + T_HIGH), 1);

    // back-to-back commands with cmd_valid held high
    prep(1'b0, 4);
    for (int i = 0; i < 4; i++) rsp[i] = 16'(16'hC000 + i);
    @(posedge clk); #1;
    cmd_write = 1'b0; cmd_addr = 32'h0400_0000; cmd_len = 9'd2; cmd_valid = 1'b1;
    for (int k = 0; k < 200 && n_done < 1; k++) @(negedge clk);
    @(posedge clk); #1 cmd_valid = 1'b0;
    wait_done("b2b", 2);
    chk("b2b.ale_h_falls", ah_fall_cyc.size(), 2);
    chk("b2b.restart_gap", (ah_fall_cyc.size() > 1 && ah_rise_cyc.size() > 0) ?
        ah_fall_cyc[1] - ah_rise_cyc[0] : -1, T_END + 1);
    chk("b2b.rd_valid", n_rv, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("b2b.rd_data[%0d]", i), (i < q_rd.size()) ? longint'(q_rd[i]) : -1, rsp[i]);
    chk("b2b.cycles2", (q_dur.size() > 1) ? q_dur[1] : -1, burst_cycles(2));

    // reset asserted during the second READ_N low
    prep(1'b0, 4);
    for (int i = 0; i < 4; i++) rsp[i] = 16'(16'h7000 + i);
    issue(1'b0, 32'h2000_0040, 9'd4);
    for (int k = 0; k < 200 && n_rfall < 2; k++) @(negedge clk);
    chk("midrst.reached_2nd_strobe", n_rfall, 2);
    #2 resetn = 1'b0;
    #1;
    chk("midrst.read_n", READ_N, 1); chk("midrst.ad_oe", AD_oe, 0);
    chk("midrst.ale_h", ALE_H, 1);   chk("midrst.ale_l", ALE_L, 1);
    chk("midrst.cmd_ready", cmd_ready, 1);
    @(posedge clk); #3 resetn = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst.rd_valid_count", n_rv, 1);
    chk("midrst.done_count", n_done, 0);
    prep(1'b0, 2);
    for (int i = 0; i < 2; i++) rsp[i] = 16'(16'h0BAD + i);
    issue(1'b0, 32'h2000_0040, 9'd2);
    wait_done("postrst", 1);
    check_burst("postrst", 1'b0, 16'h2000, 16'h0040, 2, burst_cycles(2));

    // randomized bursts against the cycle-count / data-order model
    for (int r = 0; r < 12; r++) begin
      logic        w;
      logic [31:0] a;
      logic [8:0]  l;
      int          n;
      w = 1'($urandom_range(0, 1));
      a = $urandom;
      l = 9'($urandom_range(1, 9));
      if ($urandom_range(0, 9) == 0) l = 9'd0;
      n = (l == 9'd0) ? 256 : int'(l);
      prep(w, n);
      for (int i = 0; i < 256; i++) begin
        rsp[i] = 16'($urandom);
        wq[i]  = 16'($urandom);
      end
      issue(w, a, l);
      wait_done($sformatf("rnd%0d", r), 1);
      check_burst($sformatf("rnd%0d", r), w, a[31:16], a[15:0], n, burst_cycles(n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
